branch_redirect_ctrl: RTL and testbench

Sequences control-flow redirects from the execute-stage branch unit into fetch. When the branch unit reports a taken branch for a valid execute-stage instruction, this block:
- kills younger pipeline stages;
- holds a redirect request with the target address until fetch accepts it;
- keeps killing wrong-path instructions for a programmable drain window.

It sits between execute and the fetch/PC logic and also keeps a taken-branch counter for performance monitoring.

---
 rtl/branch_redirect_ctrl_pkg.sv | 17 +
 rtl/branch_redirect_ctrl_sat_counter.sv | 33 +++
 rtl/branch_redirect_ctrl.sv | 99 +++++++++
 tb/tb_branch_redirect_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared definitions for the branch redirect controller and its perf counter.
package branch_redirect_ctrl_pkg;

  // Processor-wide address width.
  localparam int ADDR_W_DEFAULT = 32;

  // Width of the drain countdown; DRAIN_CYCLES must fit in it (0..15).
  localparam int DRAIN_W = 4;

  // Controller states with fixed encodings.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_DRAIN    = 2'd2
  } brc_state_e;

endpackage

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// Generic saturating up-counter, reusable for performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Increment on request, holding once all-ones is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !(&cnt_q)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Turns taken execute-stage branches into a held fetch redirect plus a
// flush window covering the redirect and a programmable drain period.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int ADDR         = ADDR_W_DEFAULT,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid_i,
  input  logic             branch_i,
  input  logic [ADDR-1:0]  branch_addr_i,
  input  logic             fetch_ready_i,
  output logic             redirect_valid_o,
  output logic [ADDR-1:0]  redirect_addr_o,
  output logic             flush_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] taken_cnt_o
);

  // Value loaded into the drain countdown when fetch accepts the redirect.
  localparam logic [DRAIN_W-1:0] DRAIN_INIT =
    (DRAIN_CYCLES == 0) ? '0 : DRAIN_W'(DRAIN_CYCLES - 1);

  brc_state_e         state_q, state_d;
  logic [ADDR-1:0]    target_q, target_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               accept;

  // Next-state, target capture and drain countdown; flush is the registered
  // busy state OR the same-cycle acceptance of a new branch in IDLE.
  always_comb begin
    state_d = state_q;
    target_d = target_q;
    drain_d = drain_q;
    accept = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ex_valid_i && branch_i) begin
          accept = 1'b1;
          target_d = branch_addr_i;
          state_d = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        // Request is held unchanged until fetch takes it; younger branches
        // seen here are wrong-path and ignored.
        if (fetch_ready_i) begin
          if (DRAIN_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_INIT;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    flush_o = (state_q != ST_IDLE) || accept;
  end

  // Control and target registers; reset drops any pending redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      target_q <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      target_q <= target_d;
      drain_q <= drain_d;
    end
  end

  assign redirect_valid_o = (state_q == ST_REDIRECT);
  assign redirect_addr_o  = target_q;
  assign busy_o           = (state_q != ST_IDLE);

  sat_counter #(
    .W(CNT_W)
  ) u_taken_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (accept),
    .cnt_o (taken_cnt_o)
  );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench: table-driven cycle vectors for the default build plus
// hand sequences for the zero-drain and narrow-counter builds.
module tb_branch_redirect_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Default build: DRAIN_CYCLES=2, CNT_W=16.
  logic        ev0 = 0, br0 = 0, fr0 = 0;
  logic [31:0] ad0 = 0;
  logic        rv0, fl0, bz0;
  logic [31:0] ra0;
  logic [15:0] cn0;

  branch_redirect_ctrl #(.ADDR(32), .DRAIN_CYCLES(2), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .ex_valid_i(ev0), .branch_i(br0),
    .branch_addr_i(ad0), .fetch_ready_i(fr0), .redirect_valid_o(rv0),
    .redirect_addr_o(ra0), .flush_o(fl0), .busy_o(bz0), .taken_cnt_o(cn0));

  // Zero-drain build.
  logic        ev1 = 0, br1 = 0, fr1 = 0;
  logic [31:0] ad1 = 0;
  logic        rv1, fl1, bz1;
  logic [31:0] ra1;
  logic [15:0] cn1;

  branch_redirect_ctrl #(.ADDR(32), .DRAIN_CYCLES(0), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .ex_valid_i(ev1), .branch_i(br1),
    .branch_addr_i(ad1), .fetch_ready_i(fr1), .redirect_valid_o(rv1),
    .redirect_addr_o(ra1), .flush_o(fl1), .busy_o(bz1), .taken_cnt_o(cn1));

  // Narrow-counter build.
  logic        ev2 = 0, br2 = 0, fr2 = 0;
  logic [31:0] ad2 = 0;
  logic        rv2, fl2, bz2;
  logic [31:0] ra2;
  logic [3:0]  cn2;

  branch_redirect_ctrl #(.ADDR(32), .DRAIN_CYCLES(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .ex_valid_i(ev2), .branch_i(br2),
    .branch_addr_i(ad2), .fetch_ready_i(fr2), .redirect_valid_o(rv2),
    .redirect_addr_o(ra2), .flush_o(fl2), .busy_o(bz2), .taken_cnt_o(cn2));

  typedef struct {
    logic        rst;
    logic        ev;
    logic        br;
    logic [31:0] addr;
    logic        fr;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_fl;
    logic        e_busy;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic ev, input logic br,
                     input logic [31:0] a, input logic fr, input logic rv,
                     input logic [31:0] ea, input logic fl, input logic bz,
                     input logic [15:0] c);
    vec_t v;
    v.rst = r; v.ev = ev; v.br = br; v.addr = a; v.fr = fr;
    v.e_rv = rv; v.e_addr = ea; v.e_fl = fl; v.e_busy = bz; v.e_cnt = c;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    // Each row is one cycle: inputs, then outputs expected before its edge.
    //    rst ev br addr          fr  rv  addr          fl bz cnt
    // Reset, then a branch taken immediately by fetch.
    add(1, 0, 0, 32'h0,       0,  0, 32'h0,       0, 0, 0);
    add(0, 1, 1, 32'h1000,    1,  0, 32'h0,       1, 0, 0);
    add(0, 0, 0, 32'h0,       1,  1, 32'h1000,    1, 1, 1);
    add(0, 0, 0, 32'h0,       0,  0, 32'h1000,    1, 1, 1);
    add(0, 0, 0, 32'h0,       0,  0, 32'h1000,    1, 1, 1);
    add(0, 0, 0, 32'h0,       1,  0, 32'h1000,    0, 0, 1);
    // Branch with fetch stalled 5 cycles; wrong-path 0x2000 branches ignored.
    add(0, 1, 1, 32'h1000,    0,  0, 32'h1000,    1, 0, 1);
    add(0, 0, 0, 32'h0,       0,  1, 32'h1000,    1, 1, 2);
    add(0, 1, 1, 32'h2000,    0,  1, 32'h1000,    1, 1, 2);
    add(0, 0, 0, 32'h0,       0,  1, 32'h1000,    1, 1, 2);
    add(0, 1, 1, 32'h2000,    0,  1, 32'h1000,    1, 1, 2);
    add(0, 0, 0, 32'h0,       0,  1, 32'h1000,    1, 1, 2);
    add(0, 1, 1, 32'h2000,    1,  1, 32'h1000,    1, 1, 2);
    add(0, 1, 1, 32'h2000,    1,  0, 32'h1000,    1, 1, 2);
    add(0, 1, 1, 32'h2000,    0,  0, 32'h1000,    1, 1, 2);
    add(0, 0, 0, 32'h0,       0,  0, 32'h1000,    0, 0, 2);
    // Reset while in REDIRECT, then a normal branch.
    add(0, 1, 1, 32'h3000,    0,  0, 32'h1000,    1, 0, 2);
    add(1, 0, 0, 32'h0,       0,  1, 32'h3000,    1, 1, 3);
    add(0, 0, 0, 32'h0,       0,  0, 32'h0,       0, 0, 0);
    add(0, 1, 1, 32'h4000,    1,  0, 32'h0,       1, 0, 0);
    add(0, 0, 0, 32'h0,       1,  1, 32'h4000,    1, 1, 1);
    add(0, 0, 0, 32'h0,       0,  0, 32'h4000,    1, 1, 1);
    add(0, 0, 0, 32'h0,       0,  0, 32'h4000,    1, 1, 1);
    // Valid-not-taken and taken-not-valid are not accepted.
    add(0, 1, 0, 32'h5000,    0,  0, 32'h4000,    0, 0, 1);
    add(0, 0, 1, 32'h5000,    1,  0, 32'h4000,    0, 0, 1);
    add(0, 0, 0, 32'h0,       0,  0, 32'h4000,    0, 0, 1);

    rst = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; ev0 = vecs[i].ev; br0 = vecs[i].br;
      ad0 = vecs[i].addr; fr0 = vecs[i].fr;
      #1;
      check($sformatf("v%0d redirect_valid", i), 32'(rv0), 32'(vecs[i].e_rv));
      check($sformatf("v%0d redirect_addr", i), ra0, vecs[i].e_addr);
      check($sformatf("v%0d flush", i), 32'(fl0), 32'(vecs[i].e_fl));
      check($sformatf("v%0d busy", i), 32'(bz0), 32'(vecs[i].e_busy));
      check($sformatf("v%0d taken_cnt", i), 32'(cn0), 32'(vecs[i].e_cnt));
    end
    @(negedge clk);
    rst = 1'b0; ev0 = 0; br0 = 0; fr0 = 0; ad0 = 0;

    // Zero-drain build: accept, transfer next cycle, back-to-back branch.
    @(negedge clk);
    ev1 = 1; br1 = 1; ad1 = 32'h100; fr1 = 1;
    #1;
    check("d0 accept flush", 32'(fl1), 32'd1);
    check("d0 accept busy", 32'(bz1), 32'd0);
    @(negedge clk);
    ad1 = 32'h200;
    #1;
    check("d0 redirect valid", 32'(rv1), 32'd1);
    check("d0 redirect addr", ra1, 32'h100);
    @(negedge clk);
    ad1 = 32'h300;
    #1;
    check("d0 idle busy", 32'(bz1), 32'd0);
    check("d0 idle valid", 32'(rv1), 32'd0);
    check("d0 b2b flush", 32'(fl1), 32'd1);
    check("d0 cnt after 1", 32'(cn1), 32'd1);
    @(negedge clk);
    ev1 = 0; br1 = 0; ad1 = 0;
    #1;
    check("d0 b2b redirect addr", ra1, 32'h300);
    check("d0 b2b valid", 32'(rv1), 32'd1);
    check("d0 cnt after 2", 32'(cn1), 32'd2);
    @(negedge clk);
    fr1 = 0;
    #1;
    check("d0 final flush", 32'(fl1), 32'd0);

    // Narrow counter: 17 accepted branches saturate at 15.
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      ev2 = 1; br2 = 1; ad2 = 32'(k) << 4; fr2 = 1;
      @(negedge clk);
      ev2 = 0; br2 = 0;
      repeat (2) @(negedge clk);
      if (k == 14) begin
        #1;
        check("c4 cnt after 15", 32'(cn2), 32'd15);
      end
    end
    @(negedge clk);
    fr2 = 0;
    #1;
    check("c4 idle after 17", 32'(bz2), 32'd0);
    check("c4 saturated", 32'(cn2), 32'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
